// File: rtl/te_packet_expander.sv
// rtl/te_packet_expander.sv - re-expands one trace ingress packet into per-instruction uop beats
// Optional build macro: TE_EXPANDER_CHECK_EN (last-beat consistency check driving error_o)
module te_packet_expander #(
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [IRETIRE_LEN-1:0] iretire_i,
  input  logic                   ilastsize_i,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [PRIV_LEN-1:0]    priv_i,
  input  logic [XLEN-1:0]        iaddr_i,
  output logic                   lookup_req_o,
  output logic [XLEN-1:0]        lookup_addr_o,
  input  logic                   lookup_valid_i,
  input  logic                   lookup_compressed_i,
  output logic                   uop_valid_o,
  input  logic                   uop_ready_i,
  output logic [XLEN-1:0]        uop_pc_o,
  output logic                   uop_compressed_o,
  output logic                   uop_retired_o,
  output logic                   uop_last_o,
  output logic [ITYPE_LEN-1:0]   uop_itype_o,
  output logic [CAUSE_LEN-1:0]   uop_cause_o,
  output logic [XLEN-1:0]        uop_tval_o,
  output logic [PRIV_LEN-1:0]    uop_priv_o,
  output logic                   error_o
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOOKUP     = 2'd1,
    S_EMIT       = 2'd2,
    S_EMIT_EVENT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [IRETIRE_LEN-1:0] rem_q, rem_d;
  logic                   ilastsize_q, ilastsize_d;
  logic [ITYPE_LEN-1:0]   itype_q, itype_d;
  logic [CAUSE_LEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]        tval_q, tval_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;

  logic                   pkt_ready_q, pkt_ready_d;
  logic                   lookup_req_q, lookup_req_d;
  logic [XLEN-1:0]        lookup_addr_q, lookup_addr_d;
  logic                   uop_valid_q, uop_valid_d;
  logic [XLEN-1:0]        uop_pc_q, uop_pc_d;
  logic                   uop_comp_q, uop_comp_d;
  logic                   uop_retired_q, uop_retired_d;
  logic                   uop_last_q, uop_last_d;
  logic [ITYPE_LEN-1:0]   uop_itype_q, uop_itype_d;
  logic [CAUSE_LEN-1:0]   uop_cause_q, uop_cause_d;
  logic [XLEN-1:0]        uop_tval_q, uop_tval_d;
  logic [PRIV_LEN-1:0]    uop_priv_q, uop_priv_d;

  // Instruction size in halfwords: from the live response while looking up,
  // from the latched size while the beat is being presented.
  logic [IRETIRE_LEN-1:0] size_lookup;
  logic [IRETIRE_LEN-1:0] size_emit;
  logic                   last_lookup;
  logic [XLEN-1:0]        addr_next;

  assign size_lookup = lookup_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign size_emit   = uop_comp_q ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign last_lookup = (rem_q <= size_lookup);
  assign addr_next   = addr_q + (uop_comp_q ? XLEN'(2) : XLEN'(4));

  // Next-state and next-output computation for the expander FSM
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    ilastsize_d   = ilastsize_q;
    itype_d       = itype_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    priv_d        = priv_q;
    pkt_ready_d   = pkt_ready_q;
    lookup_req_d  = lookup_req_q;
    lookup_addr_d = lookup_addr_q;
    uop_valid_d   = uop_valid_q;
    uop_pc_d      = uop_pc_q;
    uop_comp_d    = uop_comp_q;
    uop_retired_d = uop_retired_q;
    uop_last_d    = uop_last_q;
    uop_itype_d   = uop_itype_q;
    uop_cause_d   = uop_cause_q;
    uop_tval_d    = uop_tval_q;
    uop_priv_d    = uop_priv_q;

    unique case (state_q)
      S_IDLE: begin
        if (pkt_valid_i) begin
          addr_d      = iaddr_i;
          rem_d       = iretire_i;
          ilastsize_d = ilastsize_i;
          itype_d     = itype_i;
          cause_d     = cause_i;
          tval_d      = tval_i;
          priv_d      = priv_i;
          pkt_ready_d = 1'b0;
          if (iretire_i == '0) begin
            // Event-only packet: a single non-retiring beat carrying the trap info
            state_d       = S_EMIT_EVENT;
            uop_valid_d   = 1'b1;
            uop_pc_d      = iaddr_i;
            uop_comp_d    = 1'b0;
            uop_retired_d = 1'b0;
            uop_last_d    = 1'b1;
            uop_itype_d   = itype_i;
            uop_cause_d   = cause_i;
            uop_tval_d    = tval_i;
            uop_priv_d    = priv_i;
          end else begin
            state_d       = S_LOOKUP;
            lookup_req_d  = 1'b1;
            lookup_addr_d = iaddr_i;
          end
        end
      end

      S_LOOKUP: begin
        if (lookup_valid_i) begin
          state_d       = S_EMIT;
          lookup_req_d  = 1'b0;
          uop_valid_d   = 1'b1;
          uop_pc_d      = addr_q;
          uop_comp_d    = lookup_compressed_i;
          uop_retired_d = 1'b1;
          uop_last_d    = last_lookup;
          uop_itype_d   = last_lookup ? itype_q : '0;
          uop_cause_d   = last_lookup ? cause_q : '0;
          uop_tval_d    = last_lookup ? tval_q : '0;
          uop_priv_d    = priv_q;
        end
      end

      S_EMIT: begin
        if (uop_ready_i) begin
          uop_valid_d   = 1'b0;
          uop_pc_d      = '0;
          uop_comp_d    = 1'b0;
          uop_retired_d = 1'b0;
          uop_last_d    = 1'b0;
          uop_itype_d   = '0;
          uop_cause_d   = '0;
          uop_tval_d    = '0;
          uop_priv_d    = '0;
          if (uop_last_q) begin
            state_d     = S_IDLE;
            pkt_ready_d = 1'b1;
          end else begin
            // Not last means rem_q > size_emit, so the subtraction cannot underflow
            state_d       = S_LOOKUP;
            addr_d        = addr_next;
            rem_d         = rem_q - size_emit;
            lookup_req_d  = 1'b1;
            lookup_addr_d = addr_next;
          end
        end
      end

      S_EMIT_EVENT: begin
        if (uop_ready_i) begin
          state_d       = S_IDLE;
          pkt_ready_d   = 1'b1;
          uop_valid_d   = 1'b0;
          uop_pc_d      = '0;
          uop_retired_d = 1'b0;
          uop_last_d    = 1'b0;
          uop_itype_d   = '0;
          uop_cause_d   = '0;
          uop_tval_d    = '0;
          uop_priv_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output flops with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      ilastsize_q   <= 1'b0;
      itype_q       <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      priv_q        <= '0;
      pkt_ready_q   <= 1'b1;
      lookup_req_q  <= 1'b0;
      lookup_addr_q <= '0;
      uop_valid_q   <= 1'b0;
      uop_pc_q      <= '0;
      uop_comp_q    <= 1'b0;
      uop_retired_q <= 1'b0;
      uop_last_q    <= 1'b0;
      uop_itype_q   <= '0;
      uop_cause_q   <= '0;
      uop_tval_q    <= '0;
      uop_priv_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      ilastsize_q   <= ilastsize_d;
      itype_q       <= itype_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      priv_q        <= priv_d;
      pkt_ready_q   <= pkt_ready_d;
      lookup_req_q  <= lookup_req_d;
      lookup_addr_q <= lookup_addr_d;
      uop_valid_q   <= uop_valid_d;
      uop_pc_q      <= uop_pc_d;
      uop_comp_q    <= uop_comp_d;
      uop_retired_q <= uop_retired_d;
      uop_last_q    <= uop_last_d;
      uop_itype_q   <= uop_itype_d;
      uop_cause_q   <= uop_cause_d;
      uop_tval_q    <= uop_tval_d;
      uop_priv_q    <= uop_priv_d;
    end
  end

`ifdef TE_EXPANDER_CHECK_EN
  // Flag at the last-beat handshake when the final instruction overran the
  // retired count or its size disagrees with the packet's ilastsize.
  logic last_handshake;
  assign last_handshake = (state_q == S_EMIT) && uop_ready_i && uop_last_q;
  assign error_o = last_handshake &&
                   ((rem_q != size_emit) || (ilastsize_q != ~uop_comp_q));
`else
  logic unused_ilastsize;
  assign unused_ilastsize = ilastsize_q;
  assign error_o = 1'b0;
`endif

  assign pkt_ready_o      = pkt_ready_q;
  assign lookup_req_o     = lookup_req_q;
  assign lookup_addr_o    = lookup_addr_q;
  assign uop_valid_o      = uop_valid_q;
  assign uop_pc_o         = uop_pc_q;
  assign uop_compressed_o = uop_comp_q;
  assign uop_retired_o    = uop_retired_q;
  assign uop_last_o       = uop_last_q;
  assign uop_itype_o      = uop_itype_q;
  assign uop_cause_o      = uop_cause_q;
  assign uop_tval_o       = uop_tval_q;
  assign uop_priv_o       = uop_priv_q;

endmodule

// File: tb/tb_te_packet_expander.sv
// tb/tb_te_packet_expander.sv - directed self-checking bench for te_packet_expander
module tb_te_packet_expander;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] iretire;
  logic        ilastsize;
  logic [2:0]  itype;
  logic [4:0]  cause;
  logic [63:0] tval;
  logic [1:0]  priv;
  logic [63:0] iaddr;
  logic        lookup_req;
  logic [63:0] lookup_addr;
  logic        lookup_valid;
  logic        lookup_compressed;
  logic        uop_valid;
  logic        uop_ready;
  logic [63:0] uop_pc;
  logic        uop_compressed;
  logic        uop_retired;
  logic        uop_last;
  logic [2:0]  uop_itype;
  logic [4:0]  uop_cause;
  logic [63:0] uop_tval;
  logic [1:0]  uop_priv;
  logic        error;

  te_packet_expander dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .pkt_valid_i         (pkt_valid),
    .pkt_ready_o         (pkt_ready),
    .iretire_i           (iretire),
    .ilastsize_i         (ilastsize),
    .itype_i             (itype),
    .cause_i             (cause),
    .tval_i              (tval),
    .priv_i              (priv),
    .iaddr_i             (iaddr),
    .lookup_req_o        (lookup_req),
    .lookup_addr_o       (lookup_addr),
    .lookup_valid_i      (lookup_valid),
    .lookup_compressed_i (lookup_compressed),
    .uop_valid_o         (uop_valid),
    .uop_ready_i         (uop_ready),
    .uop_pc_o            (uop_pc),
    .uop_compressed_o    (uop_compressed),
    .uop_retired_o       (uop_retired),
    .uop_last_o          (uop_last),
    .uop_itype_o         (uop_itype),
    .uop_cause_o         (uop_cause),
    .uop_tval_o          (uop_tval),
    .uop_priv_o          (uop_priv),
    .error_o             (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] b_pc    [8];
  logic        b_comp  [8];
  logic        b_ret   [8];
  logic        b_last  [8];
  logic [2:0]  b_itype [8];
  logic [4:0]  b_cause [8];
  logic [63:0] b_tval  [8];
  logic [1:0]  b_priv  [8];
  int nb, nreq, nerr;

`ifdef TE_EXPANDER_CHECK_EN
  localparam int EXP_CHK_ERR = 1;
`else
  localparam int EXP_CHK_ERR = 0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_beat(input string t, input int i, input logic [63:0] pc, input logic comp,
                             input logic ret, input logic last, input logic [2:0] ity,
                             input logic [4:0] cs, input logic [63:0] tv, input logic [1:0] pv);
    check_eq($sformatf("%s_b%0d_pc", t, i), b_pc[i], pc);
    check_eq($sformatf("%s_b%0d_comp", t, i), 64'(b_comp[i]), 64'(comp));
    check_eq($sformatf("%s_b%0d_ret", t, i), 64'(b_ret[i]), 64'(ret));
    check_eq($sformatf("%s_b%0d_last", t, i), 64'(b_last[i]), 64'(last));
    check_eq($sformatf("%s_b%0d_itype", t, i), 64'(b_itype[i]), 64'(ity));
    check_eq($sformatf("%s_b%0d_cause", t, i), 64'(b_cause[i]), 64'(cs));
    check_eq($sformatf("%s_b%0d_tval", t, i), b_tval[i], tv);
    check_eq($sformatf("%s_b%0d_priv", t, i), 64'(b_priv[i]), 64'(pv));
  endtask

  // Drives one packet, answers lookups from resp (bit k = compressed for k-th
  // lookup) after 'delay' cycles, and optionally stalls one beat for stall_n cycles.
  task automatic run_pkt(input string t, input logic [31:0] iret, input logic ils,
                         input logic [2:0] ity, input logic [4:0] cs, input logic [63:0] tv,
                         input logic [1:0] pv, input logic [63:0] ia, input logic [7:0] resp,
                         input int delay, input int stall_beat, input int stall_n);
    int ri, wc, stall_left;
    logic done, prev_req, resp_prev;
    logic [63:0] prev_addr, sp;
    logic [2:0]  sit;
    nb = 0; nreq = 0; nerr = 0; ri = 0; wc = 0; stall_left = stall_n;
    done = 1'b0; prev_req = 1'b0; resp_prev = 1'b0; prev_addr = '0; sp = '0; sit = '0;
    @(negedge clk);
    pkt_valid = 1'b1; iretire = iret; ilastsize = ils; itype = ity;
    cause = cs; tval = tv; priv = pv; iaddr = ia;
    check_eq({t, "_pkt_ready_idle"}, 64'(pkt_ready), 64'd1);
    @(negedge clk);
    pkt_valid = 1'b0;
    check_eq({t, "_req_after_accept"}, 64'(lookup_req), 64'(iret != 0));
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (resp_prev) begin
        check_eq({t, "_uop_latency"}, 64'(uop_valid), 64'd1);
        resp_prev = 1'b0;
      end
      check_eq({t, "_pkt_ready_busy"}, 64'(pkt_ready), 64'd0);
      lookup_valid = 1'b0;
      uop_ready = 1'b0;
      if (lookup_req) begin
        if (!prev_req) nreq++;
        else check_eq({t, "_addr_stable"}, lookup_addr, prev_addr);
        prev_addr = lookup_addr;
        if (wc >= delay) begin
          lookup_valid = 1'b1;
          lookup_compressed = resp[ri[2:0]];
          ri++; wc = 0; resp_prev = 1'b1; prev_req = 1'b0;
        end else begin
          wc++; prev_req = 1'b1;
        end
      end else begin
        prev_req = 1'b0;
      end
      if (uop_valid) begin
        if (stall_left > 0 && nb == stall_beat) begin
          if (stall_left == stall_n) begin
            sp = uop_pc; sit = uop_itype;
          end else begin
            check_eq({t, "_stall_pc"}, uop_pc, sp);
            check_eq({t, "_stall_itype"}, 64'(uop_itype), 64'(sit));
          end
          check_eq({t, "_stall_no_req"}, 64'(lookup_req), 64'd0);
          stall_left--;
        end else begin
          uop_ready = 1'b1;
          if (nb < 8) begin
            b_pc[nb] = uop_pc; b_comp[nb] = uop_compressed; b_ret[nb] = uop_retired;
            b_last[nb] = uop_last; b_itype[nb] = uop_itype; b_cause[nb] = uop_cause;
            b_tval[nb] = uop_tval; b_priv[nb] = uop_priv;
          end
          nb++;
          if (uop_last) done = 1'b1;
        end
      end
      #1;
      if (error) nerr++;
      @(negedge clk);
    end
    uop_ready = 1'b0;
    lookup_valid = 1'b0;
    check_eq({t, "_completed"}, 64'(done), 64'd1);
    check_eq({t, "_idle_return"}, 64'(pkt_ready), 64'd1);
    check_eq({t, "_valid_drop"}, 64'(uop_valid), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; pkt_valid = 1'b0; iretire = '0; ilastsize = 1'b0; itype = '0;
    cause = '0; tval = '0; priv = '0; iaddr = '0; lookup_valid = 1'b0;
    lookup_compressed = 1'b0; uop_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("rst_pkt_ready", 64'(pkt_ready), 64'd1);
    check_eq("rst_uop_valid", 64'(uop_valid), 64'd0);
    check_eq("rst_lookup_req", 64'(lookup_req), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_pc", uop_pc, 64'd0);

    // c, n, n from 0x1000 with five halfwords
    run_pkt("A", 32'd5, 1'b1, 3'd3, 5'd7, 64'h55, 2'd3, 64'h1000, 8'b001, 0, -1, 0);
    check_eq("A_nb", 64'(nb), 64'd3);
    check_eq("A_nreq", 64'(nreq), 64'd3);
    check_eq("A_err", 64'(nerr), 64'd0);
    expect_beat("A", 0, 64'h1000, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    expect_beat("A", 1, 64'h1002, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    expect_beat("A", 2, 64'h1006, 1'b0, 1'b1, 1'b1, 3'd3, 5'd7, 64'h55, 2'd3);

    // Same packet with a 5-cycle lookup delay
    run_pkt("D", 32'd5, 1'b1, 3'd3, 5'd7, 64'h55, 2'd3, 64'h1000, 8'b001, 5, -1, 0);
    check_eq("D_nb", 64'(nb), 64'd3);
    check_eq("D_nreq", 64'(nreq), 64'd3);
    expect_beat("D", 0, 64'h1000, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    expect_beat("D", 1, 64'h1002, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    expect_beat("D", 2, 64'h1006, 1'b0, 1'b1, 1'b1, 3'd3, 5'd7, 64'h55, 2'd3);

    // Event-only packet
    run_pkt("E", 32'd0, 1'b0, 3'd1, 5'd2, 64'hdead, 2'd1, 64'h2000, 8'b0, 0, -1, 0);
    check_eq("E_nb", 64'(nb), 64'd1);
    check_eq("E_nreq", 64'(nreq), 64'd0);
    check_eq("E_err", 64'(nerr), 64'd0);
    expect_beat("E", 0, 64'h2000, 1'b0, 1'b0, 1'b1, 3'd1, 5'd2, 64'hdead, 2'd1);

    // Consumer stall of 4 cycles on the last beat
    run_pkt("S", 32'd5, 1'b1, 3'd3, 5'd7, 64'h55, 2'd2, 64'h1000, 8'b001, 1, 2, 4);
    check_eq("S_nb", 64'(nb), 64'd3);
    check_eq("S_nreq", 64'(nreq), 64'd3);
    expect_beat("S", 2, 64'h1006, 1'b0, 1'b1, 1'b1, 3'd3, 5'd7, 64'h55, 2'd2);

    // Overrun: last 32-bit instruction with one halfword left, ilastsize mismatch
    run_pkt("C", 32'd3, 1'b0, 3'd2, 5'd3, 64'h77, 2'd0, 64'h3000, 8'b000, 0, -1, 0);
    check_eq("C_nb", 64'(nb), 64'd2);
    check_eq("C_err", 64'(nerr), 64'(EXP_CHK_ERR));
    expect_beat("C", 0, 64'h3000, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
    expect_beat("C", 1, 64'h3004, 1'b0, 1'b1, 1'b1, 3'd2, 5'd3, 64'h77, 2'd0);

    // Address wrap at the top of the XLEN space
    run_pkt("W", 32'd4, 1'b1, 3'd0, 5'd0, 64'h0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 8'b000, 0, -1, 0);
    check_eq("W_nb", 64'(nb), 64'd2);
    check_eq("W_err", 64'(nerr), 64'd0);
    expect_beat("W", 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    expect_beat("W", 1, 64'h2, 1'b0, 1'b1, 1'b1, 3'd0, 5'd0, 64'h0, 2'd3);

    // Reset while a beat is presented
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      pkt_valid = 1'b1; iretire = 32'd4; ilastsize = 1'b1; itype = 3'd0; iaddr = 64'h4000;
      @(negedge clk);
      pkt_valid = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
        lookup_valid = lookup_req;
        lookup_compressed = 1'b0;
        if (uop_valid) begin
          seen = 1'b1;
          lookup_valid = 1'b0;
          rst_ni = 1'b0;
        end
        @(negedge clk);
      end
      rst_ni = 1'b1;
      check_eq("R_reached_emit", 64'(seen), 64'd1);
      check_eq("R_uop_valid", 64'(uop_valid), 64'd0);
      check_eq("R_pkt_ready", 64'(pkt_ready), 64'd1);
      check_eq("R_lookup_req", 64'(lookup_req), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/te_packet_expander.md
Name: te_packet_expander

Overview:
- Decoder-side counterpart of the trace-encoder ingress FSM.
- Consumes one ingress packet (iretire, ilastsize, itype, cause, tval, priv, iaddr) and re-expands it into one uop entry per retired instruction.
- Walks forward from iaddr; queries an instruction-size lookup port (program image) for each address.
- Sits in the verification/decoder path, feeding a reference model or trace checker.

Parameters:
- XLEN, 64, address/tval width (matches mure_pkg::XLEN)
- IRETIRE_LEN, 32, iretire width in halfwords
- ITYPE_LEN, 3, itype width
- CAUSE_LEN, 5, cause width
- PRIV_LEN, 2, privilege width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- pkt_valid_i  in  1  packet valid
- pkt_ready_o  out  1  packet accepted when valid&ready
- iretire_i  in  IRETIRE_LEN  halfwords retired in packet
- ilastsize_i  in  1  last instr size: 1 = 32-bit, 0 = 16-bit
- itype_i  in  ITYPE_LEN  packet type; 0 = none, 1 = exc, 2 = int, >2 = special
- cause_i  in  CAUSE_LEN  trap cause
- tval_i  in  XLEN  trap value
- priv_i  in  PRIV_LEN  privilege
- iaddr_i  in  XLEN  address of first retired instruction
- lookup_req_o  out  1  size query strobe, held until lookup_valid_i
- lookup_addr_o  out  XLEN  queried address
- lookup_valid_i  in  1  response valid
- lookup_compressed_i  in  1  1 = 16-bit instruction at lookup_addr_o
- uop_valid_o  out  1  uop entry valid
- uop_ready_i  in  1  consumer accepts
- uop_pc_o  out  XLEN  instruction address
- uop_compressed_o  out  1  size of instruction
- uop_retired_o  out  1  0 = event-only beat, no instruction
- uop_last_o  out  1  last beat of packet
- uop_itype_o  out  ITYPE_LEN  packet itype on last beat, else 0
- uop_cause_o  out  CAUSE_LEN  cause on last beat, else 0
- uop_tval_o  out  XLEN  tval on last beat, else 0
- uop_priv_o  out  PRIV_LEN  packet priv on all beats
- error_o  out  1  one-cycle consistency error pulse

Behaviour:
- Reset (synchronous, rst_ni low at posedge): state IDLE; all outputs 0 except pkt_ready_o = 1; internal registers cleared.
- State IDLE:
  - pkt_ready_o = 1. On handshake, latch all packet fields; addr_q = iaddr_i; rem_q = iretire_i.
  - If iretire_i == 0: go to EMIT_EVENT.
  - Otherwise: go to LOOKUP.
- State LOOKUP:
  - lookup_req_o = 1, lookup_addr_o = addr_q.
  - On lookup_valid_i: latch compressed; size = compressed ? 1 : 2 halfwords; go to EMIT.
  - lookup_valid_i outside LOOKUP is ignored.
- State EMIT:
  - uop_valid_o = 1; pc = addr_q; retired = 1.
  - last = (rem_q <= size).
  - On uop_ready_i:
    - If not last: addr_q += 2*size (XLEN wrap permitted); rem_q -= size; go to LOOKUP.
    - If last: go to IDLE.
  - Outputs are stable while valid && !ready.
- State EMIT_EVENT:
  - One beat: uop_valid_o = 1, retired = 0, pc = iaddr, last = 1, compressed = 0.
  - On ready: go to IDLE.
- pkt_ready_o is 0 outside IDLE; no packet pipelining.
- Latency:
  - Packet accepted at cycle N -> lookup_req_o at N+1.
  - Response at cycle M -> uop_valid_o at M+1.
  - Minimum 2 cycles per instruction.
- Packet with itype_i = 0 and iretire_i = 0 is still accepted and emits an event beat.
- Width: rem_q is IRETIRE_LEN wide, unsigned, never underflows; the last-beat rule guarantees this.

Optional Feature:
- Macro: TE_EXPANDER_CHECK_EN.
- Defined: error_o pulses for one cycle at the last-beat handshake on either condition:
  - rem_q != size (overrun: a 32-bit instruction with one halfword remaining);
  - ilastsize latched != !compressed.
- Emission completes normally in both cases.
- Not defined: error_o is tied 0 and no comparison logic is built.

Test Plan:
- Reset mid-EMIT (rst_ni low one cycle while uop_valid_o = 1) -> next cycle IDLE, uop_valid_o = 0, pkt_ready_o = 1.
- Packet iretire = 5, iaddr = 0x1000, ilastsize = 1, itype = 3; lookup returns c, n, n (c = 16-bit, n = 32-bit) -> three beats:
  - pc 0x1000, 0x1002, 0x1006;
  - last only on the third beat, with itype = 3;
  - error_o = 0.
- Packet iretire = 0, itype = 1, cause = 2, tval = 0xdead -> single beat: retired = 0, last = 1, cause = 2, tval = 0xdead; lookup_req_o never asserted.
- uop_ready_i held low 4 cycles during EMIT -> pc/itype stable throughout, no additional lookup, pkt_ready_o stays 0.
- With TE_EXPANDER_CHECK_EN: iretire = 3, ilastsize = 0, lookup returns n, n -> second beat last, error_o pulses once.
- Without TE_EXPANDER_CHECK_EN: same stimulus -> same beats, error_o stays 0.
- Lookup delay 0 vs 5 cycles -> identical beat sequence; lookup_addr_o stable while lookup_req_o is high.
